// File: rtl/descrambler_sync.sv
// rtl/descrambler_sync.sv - 802.11b receive descrambler (z^-7 + z^-4 + 1) with PLCP sync/SFD front end
module descrambler_sync #(
    parameter int          ONES_THRESH = 32,
    parameter logic [15:0] SFD         = 16'hF3A0,
    parameter int          SFD_TIMEOUT = 64
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic       bit_in,
    input  logic       rearm,
    output logic       bit_out,
    output logic       bit_valid,
    output logic [6:0] state_out,
    output logic       sync_locked,
    output logic       sfd_found
);

    localparam int OW = $clog2(ONES_THRESH + 1);
    localparam int TW = $clog2(SFD_TIMEOUT + 1);

    localparam logic [OW-1:0] ONES_MAX = OW'(ONES_THRESH);
    localparam logic [TW-1:0] TMO_MAX  = TW'(SFD_TIMEOUT);

    localparam logic [1:0] ST_FLUSH   = 2'd0;
    localparam logic [1:0] ST_SEARCH  = 2'd1;
    localparam logic [1:0] ST_LOCKED  = 2'd2;
    localparam logic [1:0] ST_PAYLOAD = 2'd3;

    logic [6:0]    scr_q, scr_d;
    logic          bit_out_q, bit_out_d;
    logic          bit_valid_q, bit_valid_d;
    logic          sync_locked_q, sync_locked_d;
    logic          sfd_found_q, sfd_found_d;
    logic [1:0]    fsm_q, fsm_d;
    logic [2:0]    flush_cnt_q, flush_cnt_d;
    logic [OW-1:0] ones_cnt_q, ones_cnt_d;
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic [15:0]   sfd_sr_q, sfd_sr_d;

    logic          d;
    logic [15:0]   sfd_next;
    logic [OW-1:0] ones_inc;
    logic [TW-1:0] tmo_inc;

    // Descramble the current bit and work out the next state of every register.
    always_comb begin
        d        = bit_in ^ scr_q[6] ^ scr_q[3];
        sfd_next = {d, sfd_sr_q[15:1]};
        ones_inc = (ones_cnt_q == ONES_MAX) ? ONES_MAX : ones_cnt_q + 1'b1;
        tmo_inc  = (tmo_cnt_q == TMO_MAX) ? TMO_MAX : tmo_cnt_q + 1'b1;

        scr_d         = scr_q;
        bit_out_d     = bit_out_q;
        bit_valid_d   = bit_valid_q;
        sync_locked_d = sync_locked_q;
        sfd_found_d   = 1'b0;
        fsm_d         = fsm_q;
        flush_cnt_d   = flush_cnt_q;
        ones_cnt_d    = ones_cnt_q;
        tmo_cnt_d     = tmo_cnt_q;
        sfd_sr_d      = sfd_sr_q;

        // The line is continuous, so the descrambler keeps shifting even on a rearm.
        if (enable) begin
            scr_d     = {scr_q[5:0], bit_in};
            bit_out_d = d;
        end

        if (rearm) begin
            fsm_d         = ST_FLUSH;
            flush_cnt_d   = '0;
            ones_cnt_d    = '0;
            tmo_cnt_d     = '0;
            sfd_sr_d      = '0;
            bit_valid_d   = 1'b0;
            sync_locked_d = 1'b0;
        end else if (enable) begin
            sfd_sr_d    = sfd_next;
            bit_valid_d = (fsm_q == ST_PAYLOAD);
            case (fsm_q)
                ST_FLUSH: begin
                    // Seven bits fill the shift register from the line.
                    if (flush_cnt_q == 3'd6) begin
                        flush_cnt_d = '0;
                        fsm_d       = ST_SEARCH;
                    end else begin
                        flush_cnt_d = flush_cnt_q + 3'd1;
                    end
                end
                ST_SEARCH: begin
                    if (d) begin
                        ones_cnt_d = ones_inc;
                        if (ones_inc == ONES_MAX) begin
                            fsm_d     = ST_LOCKED;
                            tmo_cnt_d = '0;
                        end
                    end else begin
                        ones_cnt_d = '0;
                    end
                end
                ST_LOCKED: begin
                    // A match outranks a timeout landing on the same bit.
                    if (sfd_next == SFD) begin
                        fsm_d       = ST_PAYLOAD;
                        sfd_found_d = 1'b1;
                    end else begin
                        tmo_cnt_d = tmo_inc;
                        if (tmo_inc == TMO_MAX) begin
                            fsm_d      = ST_SEARCH;
                            ones_cnt_d = '0;
                        end
                    end
                end
                ST_PAYLOAD: begin
                    fsm_d = ST_PAYLOAD;
                end
                default: begin
                    fsm_d = ST_FLUSH;
                end
            endcase
            sync_locked_d = (fsm_d == ST_LOCKED) || (fsm_d == ST_PAYLOAD);
        end
    end

    // State registers with synchronous reset taking priority over everything.
    always_ff @(posedge clock) begin
        if (reset) begin
            scr_q         <= '0;
            bit_out_q     <= 1'b0;
            bit_valid_q   <= 1'b0;
            sync_locked_q <= 1'b0;
            sfd_found_q   <= 1'b0;
            fsm_q         <= ST_FLUSH;
            flush_cnt_q   <= '0;
            ones_cnt_q    <= '0;
            tmo_cnt_q     <= '0;
            sfd_sr_q      <= '0;
        end else begin
            scr_q         <= scr_d;
            bit_out_q     <= bit_out_d;
            bit_valid_q   <= bit_valid_d;
            sync_locked_q <= sync_locked_d;
            sfd_found_q   <= sfd_found_d;
            fsm_q         <= fsm_d;
            flush_cnt_q   <= flush_cnt_d;
            ones_cnt_q    <= ones_cnt_d;
            tmo_cnt_q     <= tmo_cnt_d;
            sfd_sr_q      <= sfd_sr_d;
        end
    end

    assign bit_out     = bit_out_q;
    assign bit_valid   = bit_valid_q;
    assign state_out   = scr_q;
    assign sync_locked = sync_locked_q;
    assign sfd_found   = sfd_found_q;

endmodule
